// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the five-stage RV32IM pipeline.
// Resolves load-use hazards, taken-branch redirects, instruction/data memory waits and
// multi-cycle divides, and keeps a saturating count of PC stall cycles.
// Optional feature macro: MULDIV_STALL_EN (divide stall sequencing; when undefined the
// divide is treated as single-cycle, EX_DIV is ignored and DIV_START is tied low).
module pipeline_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IMEM_BUSYWAIT,
    input  logic        DMEM_BUSYWAIT,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic [4:0]  EX_RD,
    input  logic        EX_MEMREAD,
    input  logic        EX_DIV,
    input  logic        EX_BRANCH_TAKEN,
    output logic        PC_HOLD,
    output logic        IF_ID_HOLD,
    output logic        ID_EX_HOLD,
    output logic        EX_MEM_HOLD,
    output logic        MEM_WB_HOLD,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_BUBBLE,
    output logic        EX_MEM_BUBBLE,
    output logic        DIV_START,
    output logic [15:0] STALL_COUNT
);

    // Elaboration-time guard on the divide occupancy range.
    if ((DIV_CYCLES < 2) || (DIV_CYCLES > 64)) begin : g_div_cycles_range
        $error("pipeline_hazard_ctrl: DIV_CYCLES must be within 2..64");
    end

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    logic div_active;   // sequencer is in the divide-stall state
    logic div_last;     // divide counter has reached its final (release) value
    logic div_request;  // a divide in EX asks for a stall sequence
    logic start_div;    // enter the divide-stall state on this edge
    logic div_tick;     // advance the divide counter on this edge
    logic div_done;     // leave the divide-stall state on this edge

`ifdef MULDIV_STALL_EN
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_DIV     = 1'b1;
    localparam logic [5:0] DIV_RELOAD = 6'(DIV_CYCLES - 2);

    logic [0:0] state;
    logic [5:0] div_cnt;

    assign div_active  = (state == ST_DIV);
    assign div_last    = (div_cnt == 6'd0);
    assign div_request = EX_DIV;
    assign DIV_START   = start_div;

    // Divide sequencer: load the counter on start, count down while not frozen, exit on release.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_RUN;
            div_cnt <= '0;
        end else if (start_div) begin
            state   <= ST_DIV;
            div_cnt <= DIV_RELOAD;
        end else if (div_tick) begin
            div_cnt <= div_cnt - 6'd1;
        end else if (div_done) begin
            state   <= ST_RUN;
        end
    end
`else
    logic unused_div_ctrl;

    assign div_active      = 1'b0;
    assign div_last        = 1'b0;
    assign div_request     = 1'b0;
    assign DIV_START       = 1'b0;
    assign unused_div_ctrl = ^{EX_DIV, start_div, div_tick, div_done};
`endif

    // Load-use detection: a load in EX writing a non-zero register that ID is about to read.
    always_comb begin
        rs1_hit  = ID_USES_RS1 && (ID_RS1 == EX_RD);
        rs2_hit  = ID_USES_RS2 && (ID_RS2 == EX_RD);
        load_use = EX_MEMREAD && (EX_RD != 5'd0) && (rs1_hit || rs2_hit);
    end

    // Priority decode of hold/flush/bubble controls and the divide sequencer strobes.
    always_comb begin
        PC_HOLD       = 1'b0;
        IF_ID_HOLD    = 1'b0;
        ID_EX_HOLD    = 1'b0;
        EX_MEM_HOLD   = 1'b0;
        MEM_WB_HOLD   = 1'b0;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_BUBBLE  = 1'b0;
        EX_MEM_BUBBLE = 1'b0;
        start_div     = 1'b0;
        div_tick      = 1'b0;
        div_done      = 1'b0;

        if (div_active) begin
            // Divide in progress: only a data-memory wait or the final count change the picture.
            if (DMEM_BUSYWAIT) begin
                PC_HOLD     = 1'b1;
                IF_ID_HOLD  = 1'b1;
                ID_EX_HOLD  = 1'b1;
                EX_MEM_HOLD = 1'b1;
                MEM_WB_HOLD = 1'b1;
            end else if (!div_last) begin
                PC_HOLD       = 1'b1;
                IF_ID_HOLD    = 1'b1;
                ID_EX_HOLD    = 1'b1;
                EX_MEM_BUBBLE = 1'b1;
                div_tick      = 1'b1;
            end else begin
                div_done = 1'b1;
            end
        end else if (DMEM_BUSYWAIT) begin
            PC_HOLD     = 1'b1;
            IF_ID_HOLD  = 1'b1;
            ID_EX_HOLD  = 1'b1;
            EX_MEM_HOLD = 1'b1;
            MEM_WB_HOLD = 1'b1;
        end else if (div_request) begin
            PC_HOLD       = 1'b1;
            IF_ID_HOLD    = 1'b1;
            ID_EX_HOLD    = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
            start_div     = 1'b1;
        end else if (EX_BRANCH_TAKEN) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else if (load_use) begin
            PC_HOLD      = 1'b1;
            IF_ID_HOLD   = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else if (IMEM_BUSYWAIT) begin
            PC_HOLD     = 1'b1;
            IF_ID_FLUSH = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STALL_COUNT <= '0;
        end else if (PC_HOLD && (STALL_COUNT != '1)) begin
            STALL_COUNT <= STALL_COUNT + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven vectors, directed multi-cycle sequences and
// randomized stimulus against a behavioural model of the hazard controller.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned DIV_CYCLES = 32;
`ifdef MULDIV_STALL_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // Output vector bit order: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD,
    // IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, DIV_START
    localparam logic [8:0] O_NONE   = 9'b000000000;
    localparam logic [8:0] O_DMEM   = 9'b111110000;
    localparam logic [8:0] O_DIVGO  = 9'b111000011;
    localparam logic [8:0] O_DIVRUN = 9'b111000010;
    localparam logic [8:0] O_BRANCH = 9'b000001100;
    localparam logic [8:0] O_LU     = 9'b110000100;
    localparam logic [8:0] O_IMEM   = 9'b100001000;

    typedef struct packed {
        logic       imem;
        logic       dmem;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       dv;
        logic       br;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    logic        CLK;
    logic        RESET;
    logic        IMEM_BUSYWAIT, DMEM_BUSYWAIT;
    logic [4:0]  ID_RS1, ID_RS2, EX_RD;
    logic        ID_USES_RS1, ID_USES_RS2;
    logic        EX_MEMREAD, EX_DIV, EX_BRANCH_TAKEN;
    logic        PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD;
    logic        IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, DIV_START;
    logic [15:0] STALL_COUNT;
    logic [8:0]  dut_out;

    int total = 0;
    int bad   = 0;
    int m_elapsed = 0;  // divide cycles consumed (0 = no divide in flight)
    int m_stall   = 0;  // expected STALL_COUNT

    pipeline_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .IMEM_BUSYWAIT  (IMEM_BUSYWAIT),
        .DMEM_BUSYWAIT  (DMEM_BUSYWAIT),
        .ID_RS1         (ID_RS1),
        .ID_RS2         (ID_RS2),
        .ID_USES_RS1    (ID_USES_RS1),
        .ID_USES_RS2    (ID_USES_RS2),
        .EX_RD          (EX_RD),
        .EX_MEMREAD     (EX_MEMREAD),
        .EX_DIV         (EX_DIV),
        .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
        .PC_HOLD        (PC_HOLD),
        .IF_ID_HOLD     (IF_ID_HOLD),
        .ID_EX_HOLD     (ID_EX_HOLD),
        .EX_MEM_HOLD    (EX_MEM_HOLD),
        .MEM_WB_HOLD    (MEM_WB_HOLD),
        .IF_ID_FLUSH    (IF_ID_FLUSH),
        .ID_EX_BUBBLE   (ID_EX_BUBBLE),
        .EX_MEM_BUBBLE  (EX_MEM_BUBBLE),
        .DIV_START      (DIV_START),
        .STALL_COUNT    (STALL_COUNT)
    );

    assign dut_out = {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD,
                      IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, DIV_START};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic in_t mk(input logic imem, input logic dmem, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mr, input logic dv,
                               input logic br);
        in_t v;
        v.imem = imem; v.dmem = dmem; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.mr = mr; v.dv = dv; v.br = br;
        return v;
    endfunction

    // Reference behaviour: a divide occupies DIV_CYCLES-1 unfrozen hold cycles, then releases once.
    function automatic logic [8:0] model_out(input in_t v, input int elapsed);
        bit lu;
        lu = v.mr && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (DIV_EN && elapsed > 0) begin
            if (v.dmem) return O_DMEM;
            return (elapsed < int'(DIV_CYCLES) - 1) ? O_DIVRUN : O_NONE;
        end
        if (v.dmem)          return O_DMEM;
        if (DIV_EN && v.dv)  return O_DIVGO;
        if (v.br)            return O_BRANCH;
        if (lu)              return O_LU;
        if (v.imem)          return O_IMEM;
        return O_NONE;
    endfunction

    task automatic model_step(input in_t v);
        logic [8:0] o;
        o = model_out(v, m_elapsed);
        if (o[8] && m_stall < 65535) m_stall++;
        if (DIV_EN && m_elapsed > 0) begin
            if (!v.dmem) m_elapsed = (m_elapsed < int'(DIV_CYCLES) - 1) ? m_elapsed + 1 : 0;
        end else if (DIV_EN && !v.dmem && v.dv) begin
            m_elapsed = 1;
        end
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic set_in(input in_t v);
        IMEM_BUSYWAIT   = v.imem;
        DMEM_BUSYWAIT   = v.dmem;
        ID_RS1          = v.rs1;
        ID_RS2          = v.rs2;
        ID_USES_RS1     = v.u1;
        ID_USES_RS2     = v.u2;
        EX_RD           = v.rd;
        EX_MEMREAD      = v.mr;
        EX_DIV          = v.dv;
        EX_BRANCH_TAKEN = v.br;
    endtask

    // Called just after a rising edge; samples on the falling edge, advances the model on the next rising edge.
    task automatic run_cycle(input in_t v, input logic use_model, input logic [8:0] tbl_exp,
                             input string name, output logic [8:0] got);
        logic [8:0] exp;
        set_in(v);
        @(negedge CLK);
        exp = use_model ? model_out(v, m_elapsed) : tbl_exp;
        got = dut_out;
        check({name, " outputs"}, {7'd0, got}, {7'd0, exp});
        check({name, " stall_count"}, STALL_COUNT, 16'(m_stall));
        @(posedge CLK);
        model_step(v);
        #1;
    endtask

    task automatic do_reset();
        set_in('0);
        RESET = 1'b1;
        m_elapsed = 0;
        m_stall   = 0;
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t       tbl[12];
        logic [8:0] got;
        in_t        v;
        int         holds;
        int         starts;
        bit         released;
        logic [15:0] cnt_before;

        RESET = 1'b1;
        set_in('0);

        //            imem dmem rs1 rs2 u1 u2 rd mr dv br
        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE};
        tbl[1]  = '{mk(0, 0, 0, 5, 0, 1, 5, 1, 0, 0), O_LU};
        tbl[2]  = '{mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0), O_NONE};
        tbl[3]  = '{mk(0, 0, 7, 0, 1, 0, 7, 1, 0, 0), O_LU};
        tbl[4]  = '{mk(0, 0, 7, 0, 0, 1, 7, 1, 0, 0), O_NONE};
        tbl[5]  = '{mk(0, 0, 7, 7, 1, 1, 7, 0, 0, 0), O_NONE};
        tbl[6]  = '{mk(0, 0, 0, 5, 0, 1, 5, 1, 0, 1), O_BRANCH};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_BRANCH};
        tbl[8]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_IMEM};
        tbl[9]  = '{mk(1, 0, 3, 0, 1, 0, 3, 1, 0, 0), O_LU};
        tbl[10] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_BRANCH};
        tbl[11] = '{mk(1, 1, 0, 5, 0, 1, 5, 1, 0, 1), O_DMEM};

        // Reset state
        do_reset();
        check("reset outputs", {7'd0, dut_out}, 16'd0);
        check("reset stall_count", STALL_COUNT, 16'd0);

        // Single-cycle load-use followed by idle: exactly one stall cycle counted
        run_cycle(tbl[1].in, 1'b0, tbl[1].exp, "lu_first", got);
        run_cycle(tbl[0].in, 1'b0, tbl[0].exp, "lu_after", got);
        check("lu stall_count", STALL_COUNT, 16'd1);

        for (int i = 0; i < 12; i++) begin
            run_cycle(tbl[i].in, 1'b0, tbl[i].exp, $sformatf("vec%0d", i), got);
        end

        // IMEM wait for two cycles
        cnt_before = STALL_COUNT;
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(v, 1'b0, O_IMEM, "imem_c0", got);
        run_cycle(v, 1'b0, O_IMEM, "imem_c1", got);
        check("imem stall delta", STALL_COUNT - cnt_before, 16'd2);

`ifdef MULDIV_STALL_EN
        // Divide with EX_DIV held: one start, DIV_CYCLES-1 holds, one release, then restart
        do_reset();
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        holds = 0; starts = 0; released = 0;
        for (int c = 0; c < 200 && !released; c++) begin
            run_cycle(v, 1'b1, O_NONE, "div_hold", got);
            if (got[8]) holds++; else released = 1;
            if (got[0]) starts++;
        end
        check("div released", {15'd0, released}, 16'd1);
        check("div hold cycles", 16'(holds), 16'(DIV_CYCLES - 1));
        check("div start pulses", 16'(starts), 16'd1);
        check("div stall_count", STALL_COUNT, 16'(DIV_CYCLES - 1));
        run_cycle(v, 1'b1, O_NONE, "div_b2b", got);
        check("div b2b restart", {15'd0, got[0]}, 16'd1);

        // Divide with a 3-cycle data-memory wait in the middle
        do_reset();
        holds = 0; released = 0;
        for (int c = 0; c < 200 && !released; c++) begin
            v = mk(0, (c >= 5 && c < 8), 0, 0, 0, 0, 0, 0, (c == 0), 0);
            run_cycle(v, 1'b1, O_NONE, "div_dmem", got);
            if (got[8]) holds++; else released = 1;
            if (c >= 5 && c < 8) check("div dmem all holds", {11'd0, got[8:4]}, 16'h1F);
        end
        check("div_dmem released", {15'd0, released}, 16'd1);
        check("div_dmem hold cycles", 16'(holds), 16'(DIV_CYCLES + 2));
        check("div_dmem stall_count", STALL_COUNT, 16'(DIV_CYCLES + 2));

        // Asynchronous reset in the middle of a divide
        do_reset();
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, O_NONE, "divrst_start", got);
        for (int c = 0; c < 3; c++) run_cycle('0, 1'b1, O_NONE, "divrst_mid", got);
        set_in('0);
        #1;
        check("divrst before reset", {7'd0, dut_out}, {7'd0, O_DIVRUN});
        RESET = 1'b1;
        #1;
        check("divrst outputs", {7'd0, dut_out}, 16'd0);
        check("divrst stall_count", STALL_COUNT, 16'd0);
        m_elapsed = 0;
        m_stall   = 0;
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        run_cycle('0, 1'b0, O_NONE, "divrst_after", got);
`else
        // Divide support not built: EX_DIV must not stall
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_cycle(v, 1'b0, O_NONE, "nodiv_c0", got);
        run_cycle(v, 1'b0, O_NONE, "nodiv_c1", got);
        check("nodiv div_start", {15'd0, DIV_START}, 16'd0);
        holds = 0; starts = 0; released = 0;
        cnt_before = STALL_COUNT;
        check("nodiv stall_count", STALL_COUNT, cnt_before);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v.imem = ($urandom_range(0, 99) < 15);
            v.dmem = ($urandom_range(0, 99) < 10);
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.u1   = 1'($urandom_range(0, 1));
            v.u2   = 1'($urandom_range(0, 1));
            v.rd   = 5'($urandom_range(0, 3));
            v.mr   = ($urandom_range(0, 99) < 40);
            v.dv   = ($urandom_range(0, 99) < 3);
            v.br   = ($urandom_range(0, 99) < 15);
            run_cycle(v, 1'b1, O_NONE, "rand", got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage RV32IM pipeline. It watches the ID and EX stages and both memory busy-waits, then drives hold, flush and bubble controls into the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It resolves load-use hazards, taken-branch/jump redirects, memory stalls and multi-cycle divides. A state machine sequences divide stalls, and a saturating counter reports stall cycles for performance debug.

## Interface
Parameters:
- DIV_CYCLES, 32: total EX-stage occupancy of a DIV/DIVU/REM/REMU. Legal range 2..64.

Ports:
- CLK  input  1  pipeline clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IMEM_BUSYWAIT  input  1  instruction memory not ready.
- DMEM_BUSYWAIT  input  1  data memory not ready.
- ID_RS1, ID_RS2  input  5 each  source registers of the instruction in ID.
- ID_USES_RS1, ID_USES_RS2  input  1 each  ID instruction reads that source.
- EX_RD  input  5  destination register of the instruction in EX.
- EX_MEMREAD  input  1  instruction in EX is a load.
- EX_DIV  input  1  instruction in EX is a divide/remainder op.
- EX_BRANCH_TAKEN  input  1  taken branch, JAL or JALR resolved in EX.
- PC_HOLD  output  1  PC keeps its value.
- IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD  output  1 each  register keeps its contents. Wired to each register's BUSYWAIT.
- IF_ID_FLUSH  output  1  IF_ID loads a NOP.
- ID_EX_BUBBLE  output  1  ID_EX loads all-zero control signals.
- EX_MEM_BUBBLE  output  1  EX_MEM loads all-zero control signals.
- DIV_START  output  1  single-cycle start pulse to the divider.
- STALL_COUNT  output  16  saturating count of cycles in which PC_HOLD was 1.

## Operation
- State register STATE ∈ {RUN, DIV}. Counter DIV_CNT is 6 bits.
- Outputs are combinational from STATE, DIV_CNT and the inputs.
- Outputs that are not asserted by the active case are 0.
- Load-use hazard (LU): EX_MEMREAD && EX_RD≠0 && ((ID_USES_RS1 && ID_RS1==EX_RD) || (ID_USES_RS2 && ID_RS2==EX_RD)).

Priority within RUN, highest first:
1. DMEM_BUSYWAIT: all five holds = 1. No flush, no bubble. STATE unchanged. This overrides everything below.
2. EX_DIV: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD = 1; EX_MEM_BUBBLE = 1; DIV_START = 1. Next: STATE=DIV, DIV_CNT=DIV_CYCLES-2.
3. EX_BRANCH_TAKEN: IF_ID_FLUSH = 1, ID_EX_BUBBLE = 1, PC loads target (no PC_HOLD). LU is ignored.
4. LU: PC_HOLD, IF_ID_HOLD = 1; ID_EX_BUBBLE = 1. Exactly one bubble, because next cycle the load has left EX.
5. IMEM_BUSYWAIT: PC_HOLD = 1, IF_ID_FLUSH = 1. Downstream stages advance.

In DIV:
- Same outputs as case 2, except DIV_START = 0.
- DIV_CNT decrements each cycle, unless DMEM_BUSYWAIT is 1, in which case the counter freezes and all holds = 1.
- When DIV_CNT==0 and DMEM_BUSYWAIT is 0: no stall outputs, so the divide result advances. Next STATE=RUN.
- EX_DIV, EX_BRANCH_TAKEN and LU are ignored in DIV.

Other behaviour:
- STATE=DIV already has IF_ID held, so IMEM_BUSYWAIT has no effect there.
- STALL_COUNT increments on every edge where PC_HOLD=1 and saturates at 16'hFFFF.

## Timing
Reset values:
- While RESET=1: STATE=RUN, DIV_CNT=0, STALL_COUNT=0.
- Outputs then follow RUN decode, which is all zero when the inputs are zero.

Stall lengths:
- Load-use costs exactly 1 cycle.
- A taken branch costs 2 squashed instructions, with 0 hold cycles.
- A divide holds upstream for DIV_CYCLES-1 cycles, plus any DMEM_BUSYWAIT cycles. It then releases for one cycle, and the next edge returns STATE to RUN.

Edge cases:
- RESET asserted mid-divide: returns to RUN immediately and asynchronously. No DIV_START is reissued until EX_DIV is seen again in RUN.
- Back-to-back divides: the second divide is seen in EX on the first RUN cycle and restarts the sequence, with DIV_START pulsing again.

## Configuration
- MULDIV_STALL_EN defined: DIV state, DIV_CNT and DIV_START are built as described above.
- MULDIV_STALL_EN undefined: EX_DIV is ignored and DIV_START is tied to 0. The divide is treated as single-cycle. The DIV state and counter are not synthesized, and DIV_CYCLES is unused.

## Test plan
- Reset, then all inputs 0 → all outputs 0, STALL_COUNT=0.
- EX_MEMREAD=1, EX_RD=5, ID_USES_RS2=1, ID_RS2=5 for one cycle → PC_HOLD=IF_ID_HOLD=ID_EX_BUBBLE=1 for 1 cycle; STALL_COUNT becomes 1. Repeat with EX_RD=0 → no stall.
- LU together with EX_BRANCH_TAKEN=1 → IF_ID_FLUSH=ID_EX_BUBBLE=1, PC_HOLD=0.
- DIV_CYCLES=32, EX_DIV held 1 → DIV_START pulses once; holds and EX_MEM_BUBBLE are asserted for exactly 31 cycles, then one release cycle; STALL_COUNT=31.
- During a divide, DMEM_BUSYWAIT=1 for 3 cycles → all holds=1 and DIV_CNT frozen; total stall becomes 34 cycles. Assert RESET mid-divide → STATE=RUN and outputs 0 immediately.
- IMEM_BUSYWAIT=1 for 2 cycles → PC_HOLD=IF_ID_FLUSH=1 for 2 cycles, ID_EX/EX_MEM/MEM_WB holds=0. Build without MULDIV_STALL_EN and assert EX_DIV → no stall, DIV_START=0.
